// File: rtl/fsk2_mod_pkg.sv
// Shared 2FSK definitions: FSM states, mid-scale code, default tones and timing.
// Also provides the quarter-wave sine generator used to build the ROM.
package fsk2_mod_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [15:0] FSK2_MID            = 16'h8000;
  localparam int          DEF_SAMPLES_PER_BIT = 200;
  localparam int          DEF_PHASE_W         = 32;
  localparam int          DEF_LUT_AW          = 8;
  localparam longint      DEF_F0_INC          = 64'sd42_949_673;  // 50 kHz at 5 MHz
  localparam longint      DEF_F1_INC          = 64'sd85_899_346;  // 100 kHz at 5 MHz

  // pi in Q30 fixed point
  localparam longint PI_Q30 = 64'sd3_373_259_426;

  // round(32767*sin(k*pi/(2*2^aw))) in integer arithmetic, evaluated at elaboration.
  // Taylor series to x^13 keeps the error far below one output LSB over [0, pi/2).
  function automatic logic [14:0] quarter_sine(input int k, input int aw);
    longint x;
    longint term;
    longint acc;
    longint scaled;
    x    = (longint'(k) * PI_Q30) >>> (aw + 1);
    term = x;
    acc  = x;
    for (int n = 1; n <= 6; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -(term / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    scaled = (acc * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
    if (scaled > 64'sd32767) scaled = 64'sd32767;
    if (scaled < 64'sd0)     scaled = 64'sd0;
    return scaled[14:0];
  endfunction

endpackage

// File: rtl/fsk2_mod_if.sv
// Bit-input handshake plus sample output bundle of the 2FSK modulator.
// master = upstream bit source / sample consumer, slave = the modulator.
interface fsk2_mod_if;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        tx_flag;
  logic [15:0] tx;
  logic        busy;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, tx_flag, tx, busy
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, tx_flag, tx, busy
  );
endinterface

// File: rtl/fsk2_sine_lut.sv
// Quarter-wave sine ROM with quadrant folding; returns sign and 15-bit magnitude.
// Latency: combinational.
// Backpressure: none, pure lookup.
module fsk2_sine_lut
  import fsk2_mod_pkg::*;
#(
  parameter int LUT_AW = DEF_LUT_AW
) (
  input  logic [LUT_AW+1:0] addr,
  output logic [14:0]       mag,
  output logic              neg
);

  localparam int DEPTH = 1 << LUT_AW;

  logic [14:0]       rom [DEPTH];
  logic [1:0]        quad;
  logic [LUT_AW-1:0] idx;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [14:0] ENTRY = quarter_sine(k, LUT_AW);
    assign rom[k] = ENTRY;
  end

  // Odd quadrants read the quarter wave backwards; the upper half is negative.
  always_comb begin
    quad = addr[LUT_AW+1:LUT_AW];
    idx  = quad[0] ? ~addr[LUT_AW-1:0] : addr[LUT_AW-1:0];
    mag  = rom[idx];
    neg  = quad[1];
  end

endmodule

// File: rtl/fsk2_mod.sv
// 2FSK modulator: serial bits in, continuous-phase offset-binary sine samples out.
// Latency: first sample (with tx_flag) one clock after a bit is accepted.
// Backpressure: bit_ready only in IDLE or on the last sample of a symbol; held bits wait.
module fsk2_mod
  import fsk2_mod_pkg::*;
#(
  parameter int                 SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
  parameter int                 PHASE_W         = DEF_PHASE_W,
  parameter logic [PHASE_W-1:0] F0_INC          = PHASE_W'(DEF_F0_INC),
  parameter logic [PHASE_W-1:0] F1_INC          = PHASE_W'(DEF_F1_INC),
  parameter int                 LUT_AW          = DEF_LUT_AW
) (
  input logic         sys_clk,
  input logic         sys_rst,
  fsk2_mod_if.slave   bus
);

  localparam int               CNT_W    = $clog2(SAMPLES_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_BIT - 1);

  state_t             state, state_nxt;
  logic               sym_bit, sym_bit_nxt;
  logic [CNT_W-1:0]   samp_cnt, cnt_nxt;
  logic [PHASE_W-1:0] phase, phase_nxt;
  logic               flag_nxt;
  logic               accept;
  logic [14:0]        lut_mag;
  logic               lut_neg;
  logic [15:0]        sample;
  logic [15:0]        tx_r;
  logic               tx_flag_r;
  logic               busy_r;

  assign bus.bit_ready = ~sys_rst & ((state == ST_IDLE) | (samp_cnt == LAST_CNT));
  assign accept        = bus.bit_valid & bus.bit_ready;

  // Next-state, symbol counter and phase accumulator update.
  always_comb begin
    state_nxt   = state;
    sym_bit_nxt = sym_bit;
    cnt_nxt     = samp_cnt;
    phase_nxt   = phase;
    flag_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        phase_nxt = '0;
        cnt_nxt   = '0;
        if (accept) begin
          state_nxt   = ST_SEND;
          sym_bit_nxt = bus.bit_in;
          flag_nxt    = 1'b1;
        end
      end
      ST_SEND: begin
        // Phase always advances by the current symbol's step, so a following
        // bit starts exactly where this one would have continued.
        phase_nxt = phase + (sym_bit ? F1_INC : F0_INC);
        if (samp_cnt == LAST_CNT) begin
          cnt_nxt = '0;
          if (accept) begin
            sym_bit_nxt = bus.bit_in;
          end else begin
            state_nxt = ST_IDLE;
            phase_nxt = '0;
          end
        end else begin
          cnt_nxt = samp_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        phase_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The ROM is addressed with the next phase so tx lines up with the phase register.
  fsk2_sine_lut #(
    .LUT_AW (LUT_AW)
  ) u_lut (
    .addr (phase_nxt[PHASE_W-1 -: LUT_AW+2]),
    .mag  (lut_mag),
    .neg  (lut_neg)
  );

  // Offset-binary sample; magnitude tops out at 32767 so neither side overflows.
  always_comb begin
    sample = lut_neg ? (FSK2_MID - {1'b0, lut_mag}) : (FSK2_MID + {1'b0, lut_mag});
  end

  // State, counter, phase and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      sym_bit   <= 1'b0;
      samp_cnt  <= '0;
      phase     <= '0;
      tx_r      <= FSK2_MID;
      tx_flag_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sym_bit   <= sym_bit_nxt;
      samp_cnt  <= cnt_nxt;
      phase     <= phase_nxt;
      tx_r      <= (state_nxt == ST_SEND) ? sample : FSK2_MID;
      tx_flag_r <= flag_nxt;
      busy_r    <= (state_nxt == ST_SEND);
    end
  end

  assign bus.tx      = tx_r;
  assign bus.tx_flag = tx_flag_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_fsk2_mod.sv
// Scoreboard bench for fsk2_mod: stimulus queues ideal samples from a sin() model,
// a negedge monitor pops and compares whenever busy is high.
module tb_fsk2_mod;

  localparam longint unsigned F0   = 64'd42_949_673;
  localparam longint unsigned F1   = 64'd85_899_346;
  localparam int              SPB  = 200;
  localparam real             PI   = 3.141592653589793;

  typedef struct {
    logic [15:0] tx;
    logic        flag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rst_q = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   b[$];

  fsk2_mod_if bus();

  fsk2_mod dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic void chk(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endfunction

  // Ideal sample: quarter-wave convention, odd quadrants mirrored, upper half negated.
  function automatic logic [15:0] model_sample(input longint unsigned ph);
    int  a, q, i, k, mag;
    real ang;
    a   = int'((ph >> 22) & 64'd1023);
    q   = a / 256;
    i   = a % 256;
    k   = (q % 2 == 1) ? 255 - i : i;
    ang = PI * real'(k) / 512.0;
    mag = int'($floor(32767.0 * $sin(ang) + 0.5));
    return (q >= 2) ? 16'(32768 - mag) : 16'(32768 + mag);
  endfunction

  task automatic push_burst(input bit bits[$]);
    longint unsigned ph;
    exp_t e;
    ph = 0;
    foreach (bits[i]) begin
      for (int s = 0; s < SPB; s++) begin
        e.tx   = model_sample(ph);
        e.flag = (i == 0 && s == 0);
        exp_q.push_back(e);
        ph = (ph + (bits[i] ? F1 : F0)) & 64'hFFFF_FFFF;
      end
    end
  endtask

  // Returns at the accepting edge + 1 time unit with acc = that cycle number.
  task automatic wait_accept(output int acc);
    int n;
    bit rdy;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 1000) begin
      @(negedge clk);
      rdy = bus.bit_ready;
      n++;
    end
    if (!rdy) begin
      chk("accept_timeout", rdy, n, 0);
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
  endtask

  task automatic wait_idle();
    int n;
    bit idle;
    n    = 0;
    idle = 1'b0;
    while (!idle && n < 2000) begin
      @(negedge clk);
      idle = !bus.busy;
      n++;
    end
    if (!idle) chk("idle_timeout", idle, n, 0);
    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_burst(input bit bits[$]);
    int acc, prev;
    prev = 0;
    push_burst(bits);
    foreach (bits[i]) begin
      bus.bit_in    = bits[i];
      bus.bit_valid = 1'b1;
      wait_accept(acc);
      if (i > 0) chk("b2b_accept_spacing", (acc - prev) == SPB, acc - prev, SPB);
      prev = acc;
    end
    bus.bit_valid = 1'b0;
  endtask

  // bit_valid raised at samp_cnt 57 with a wandering bit_in; only the value at the end counts.
  task automatic mid_symbol_test(input bit b0, input bit b1);
    int acc0, acc1, early;
    bit bb[$];
    early = 0;
    bb    = {b0, b1};
    push_burst(bb);
    bus.bit_in    = b0;
    bus.bit_valid = 1'b1;
    wait_accept(acc0);
    bus.bit_valid = 1'b0;
    repeat (57) @(posedge clk);
    #1;
    bus.bit_in    = ~b1;
    bus.bit_valid = 1'b1;
    for (int c = 57; c < SPB - 1; c++) begin
      @(negedge clk);
      if (bus.bit_ready) early++;
      @(posedge clk);
      #1;
      bus.bit_in = (c < 195) ? 1'($urandom) : b1;
    end
    chk("mid_valid_no_early_ready", early == 0, early, 0);
    wait_accept(acc1);
    chk("mid_valid_accept_at_end", (acc1 - acc0) == SPB, acc1 - acc0, SPB);
    bus.bit_valid = 1'b0;
  endtask

  task automatic reset_test();
    int acc;
    bit bb[$];
    bb = {1'b1};
    push_burst(bb);
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    wait_accept(acc);
    bus.bit_valid = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: reset state, scoreboard samples while busy, quiet idle output otherwise.
  always @(negedge clk) begin
    if (rst) begin
      if (rst_q) begin
        chk("rst_tx", bus.tx == 16'h8000, bus.tx, 16'h8000);
        chk("rst_flag", bus.tx_flag == 1'b0, bus.tx_flag, 0);
        chk("rst_busy", bus.busy == 1'b0, bus.busy, 0);
        chk("rst_ready", bus.bit_ready == 1'b0, bus.bit_ready, 0);
      end
    end else if (bus.busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", 1'b0, bus.tx, -1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tx_sample",
            (int'(bus.tx) - int'(mon_e.tx) <= 1) && (int'(mon_e.tx) - int'(bus.tx) <= 1),
            bus.tx, mon_e.tx);
        chk("tx_flag", bus.tx_flag == mon_e.flag, bus.tx_flag, mon_e.flag);
      end
    end else if (rst_q == 1'b0) begin
      chk("idle_tx", bus.tx == 16'h8000, bus.tx, 16'h8000);
      chk("idle_flag", bus.tx_flag == 1'b0, bus.tx_flag, 0);
      chk("idle_ready", bus.bit_ready == 1'b1, bus.bit_ready, 1);
    end
  end

  initial begin
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    b = {1'b0};
    send_burst(b);
    wait_idle();
    b = {1'b1};
    send_burst(b);
    wait_idle();
    b = {1'b0, 1'b1, 1'b1, 1'b0};
    send_burst(b);
    wait_idle();
    mid_symbol_test(1'b0, 1'b1);
    wait_idle();
    mid_symbol_test(1'b1, 1'b0);
    wait_idle();
    reset_test();
    wait_idle();

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 4);
      b = {};
      for (int j = 0; j < n; j++) b.push_back(1'($urandom_range(0, 1)));
      send_burst(b);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    chk("final_queue_empty", exp_q.size() == 0, exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
